store_buffer: RTL and testbench

- Write buffer between the core's memory stage and the 64-word data memory.
- Queues stores in order and drains them to the memory's single shared address port one per cycle whenever the core is not loading.
- Forwards the youngest matching buffered data to loads, so loads never see stale memory.
- Lets the core retire stores without stalling on the memory write cycle.

---
 rtl/store_buffer_pkg.sv | 14 +
 rtl/store_buffer_if.sv | 37 +++
 rtl/store_buffer.sv | 86 ++++++++
 tb/tb_store_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and default widths for the store buffer and its bus interface.
// Default widths match the 64-word, 32-bit data memory.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_ADDR_W = 6;
  localparam int unsigned SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core/memory-side bus of the store buffer.
// The master modport is the core plus the data memory; the slave modport is the buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              flush;
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, flush,
    input  st_ready, ld_hit, ld_data, mem_write, mem_addr, mem_data_in, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, flush,
    output st_ready, ld_hit, ld_data, mem_write, mem_addr, mem_data_in, empty, count
  );

endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: queues core stores, drains one per idle memory cycle,
// and forwards the youngest matching buffered data to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  store_buffer_if.slave sb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic      push;
  logic      pop;
  sb_entry_t head;

  assign head = entries[rd_ptr];

  // rst_n gates the outputs so nothing leaks onto the memory port while in reset.
  assign sb.st_ready   = rst_n && (count_q != CNT_W'(DEPTH)) && !sb.flush;
  assign sb.empty      = (count_q == '0);
  assign sb.mem_write  = !sb.empty && !sb.ld_req;
  assign sb.mem_addr   = !rst_n ? '0 : (sb.mem_write ? head.addr : sb.ld_addr);
  assign sb.mem_data_in = rst_n ? head.data : '0;
  assign sb.count      = count_q;

  assign push = sb.st_valid && sb.st_ready;
  assign pop  = sb.mem_write;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage has no reset; count_q alone defines which entries are
  // valid, so stale contents are never observed and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= '{addr: sb.st_addr, data: sb.st_data};
  end

  // Priority search from youngest (wr_ptr-1) to oldest valid entry.
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = wr_ptr - PTR_W'(i + 1);
      if (!fwd_hit && (CNT_W'(i) < count_q) && (entries[idx].addr == sb.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  assign sb.ld_hit  = fwd_hit;
  assign sb.ld_data = fwd_data;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: scoreboard of accepted stores checked
// against every memory write, plus a behavioural 64-word data memory.
module tb_store_buffer;
  import store_buffer_pkg::*;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sbq[$];
  logic [31:0] dmem [64];

  store_buffer_if #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) sb ();

  store_buffer #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory commits on the same edge the buffer pops its head.
  always @(posedge clk) begin
    if (sb.mem_write) dmem[sb.mem_addr] <= sb.mem_data_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge: drains are checked against the scoreboard,
  // accepted stores are pushed onto it.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (sb.mem_write) begin
      check("drain_has_expected", (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("drain_addr", sb.mem_addr, e.addr);
        check("drain_data", sb.mem_data_in, e.data);
      end
    end
    if (sb.st_valid && sb.st_ready) sbq.push_back('{addr: sb.st_addr, data: sb.st_data});
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [5:0] a, input logic [31:0] d);
    sb.st_valid = 1'b1;
    sb.st_addr  = a;
    sb.st_data  = d;
    tick();
    sb.st_valid = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < 16 && !sb.empty; i++) tick();
    #1;
    check(tag, sb.empty, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    sb.st_valid = 1'b0;
    sb.st_addr  = '0;
    sb.st_data  = '0;
    sb.ld_req   = 1'b0;
    sb.ld_addr  = 6'd7;
    sb.flush    = 1'b0;
    #2;
    check("rst_st_ready", sb.st_ready, 0);
    check("rst_empty", sb.empty, 1);
    check("rst_count", sb.count, 0);
    check("rst_mem_write", sb.mem_write, 0);
    check("rst_ld_hit", sb.ld_hit, 0);
    check("rst_ld_data", sb.ld_data, 0);
    check("rst_mem_addr", sb.mem_addr, 0);
    check("rst_mem_data_in", sb.mem_data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single store drains on the following cycle.
    sb.ld_addr  = 6'd0;
    sb.st_valid = 1'b1;
    sb.st_addr  = 6'd3;
    sb.st_data  = 32'hAA;
    #1;
    check("t1_st_ready", sb.st_ready, 1);
    check("t1_no_passthru", sb.mem_write, 0);
    tick();
    sb.st_valid = 1'b0;
    #1;
    check("t1_mem_write", sb.mem_write, 1);
    check("t1_mem_addr", sb.mem_addr, 3);
    check("t1_mem_data", sb.mem_data_in, 32'hAA);
    tick();
    check("t1_empty", sb.empty, 1);
    check("t1_dmem3", dmem[3], 32'hAA);

    // Forwarding picks the youngest match; the store being enqueued is not searched.
    sb.ld_req  = 1'b1;
    sb.ld_addr = 6'd5;
    sb.st_valid = 1'b1;
    sb.st_addr  = 6'd5;
    sb.st_data  = 32'h11;
    #1;
    check("t2_no_bypass", sb.ld_hit, 0);
    tick();
    store(6'd5, 32'h22);
    #1;
    check("t2_count", sb.count, 2);
    check("t2_load_wins", sb.mem_write, 0);
    check("t2_mem_addr_load", sb.mem_addr, 5);
    check("t2_hit", sb.ld_hit, 1);
    check("t2_hit_data", sb.ld_data, 32'h22);
    sb.ld_addr = 6'd6;
    #1;
    check("t2_miss", sb.ld_hit, 0);
    check("t2_miss_data", sb.ld_data, 0);
    sb.ld_req = 1'b0;
    drain_all("t2_drained");

    // Fill to DEPTH under load pressure, then drain in order.
    sb.ld_req = 1'b1;
    for (int i = 0; i < 4; i++) store(6'(10 + i), 32'h100 + i);
    sb.st_valid = 1'b1;
    sb.st_addr  = 6'd14;
    sb.st_data  = 32'h999;
    #1;
    check("t3_full_count", sb.count, 4);
    check("t3_full_ready", sb.st_ready, 0);
    tick();
    check("t3_fifth_rejected", sb.count, 4);
    sb.st_valid = 1'b0;
    sb.ld_req   = 1'b0;
    #1;
    check("t3_full_drain_ready", sb.st_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_strobe", sb.mem_write, 1);
      check("t3_drain_count", sb.count, 4 - i);
      tick();
    end
    check("t3_empty", sb.empty, 1);
    check("t3_dmem13", dmem[13], 32'h103);

    // Simultaneous enqueue and drain across a pointer wrap.
    sb.ld_req = 1'b1;
    store(6'd20, 32'h200);
    store(6'd21, 32'h201);
    sb.ld_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.st_valid = 1'b1;
      sb.st_addr  = 6'(22 + i);
      sb.st_data  = 32'h300 + i;
      #1;
      check("t4_drain_strobe", sb.mem_write, 1);
      check("t4_ready", sb.st_ready, 1);
      tick();
      check("t4_count_steady", sb.count, 2);
    end
    sb.st_valid = 1'b0;
    drain_all("t4_drained");
    check("t4_sb_empty", sbq.size(), 0);

    // Flush blocks enqueue while the buffer empties.
    sb.ld_req = 1'b1;
    for (int i = 0; i < 3; i++) store(6'(30 + i), 32'h400 + i);
    sb.ld_req   = 1'b0;
    sb.flush    = 1'b1;
    sb.st_valid = 1'b1;
    sb.st_addr  = 6'd33;
    sb.st_data  = 32'h4FF;
    #1;
    check("t5_flush_ready", sb.st_ready, 0);
    for (int i = 0; i < 3; i++) tick();
    check("t5_empty", sb.empty, 1);
    check("t5_still_blocked", sb.st_ready, 0);
    sb.st_valid = 1'b0;
    sb.flush    = 1'b0;
    #1;
    check("t5_ready_again", sb.st_ready, 1);

    // Reset mid-drain discards the remaining store.
    store(6'd1, 32'h9);
    drain_all("t6_pre_drained");
    check("t6_dmem1_pre", dmem[1], 32'h9);
    sb.ld_req = 1'b1;
    store(6'd0, 32'h55);
    store(6'd1, 32'h77);
    sb.ld_req = 1'b0;
    #1;
    check("t6_drain_first", sb.mem_addr, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", sb.count, 0);
    check("t6_rst_empty", sb.empty, 1);
    check("t6_rst_mem_write", sb.mem_write, 0);
    check("t6_rst_ready", sb.st_ready, 0);
    check("t6_dropped_entry", sbq.size(), 1);
    sbq.delete();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_dmem0", dmem[0], 32'h55);
    check("t6_dmem1_kept", dmem[1], 32'h9);
    check("t6_post_empty", sb.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
